// File: rtl/if_id_latch.sv
// IF/ID pipeline register for the MIPS core.
// Each edge it captures PC+4 and the fetched instruction. It supports stall,
// flush (inserts a NOP bubble) and HALT-word detection. A HALT word freezes the
// front end until reset. A valid flag and a saturating fetch counter are provided
// for the debug unit.
//
// Ports:
//   i_clk          clock; all state updates on its rising edge
//   i_reset        synchronous, active-high reset
//   i_enable       1 = load new fetch, 0 = stall (hold)
//   i_flush        1 = replace stage contents with a NOP bubble
//   i_pc_plus4     PC+4 of the fetched instruction
//   i_instr        instruction word from instruction memory
//   o_pc_plus4     registered PC+4 to ID
//   o_instr        registered instruction to ID
//   o_valid        o_instr is a real fetched instruction
//   o_halt         sticky, set once a HALT word has been latched
//   o_instr_count  saturating count of instructions latched with valid=1
module if_id_latch #(
    parameter int unsigned          NB_ADDR   = 32,
    parameter int unsigned          NB_INSTR  = 32,
    parameter int unsigned          NB_CNT    = 16,
    parameter logic [NB_INSTR-1:0]  HALT_WORD = NB_INSTR'(32'hFFFF_FFFF)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_flush,
    input  logic [NB_ADDR-1:0]  i_pc_plus4,
    input  logic [NB_INSTR-1:0] i_instr,
    output logic [NB_ADDR-1:0]  o_pc_plus4,
    output logic [NB_INSTR-1:0] o_instr,
    output logic                o_valid,
    output logic                o_halt,
    output logic [NB_CNT-1:0]   o_instr_count
);

    localparam logic [NB_CNT-1:0] CNT_MAX = '1;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [NB_ADDR-1:0]  pc_q,    pc_d;
    logic [NB_INSTR-1:0] instr_q, instr_d;
    logic                valid_q, valid_d;
    logic                halt_q,  halt_d;
    logic [NB_CNT-1:0]   cnt_q,   cnt_d;

    // State and stage registers; reset has priority over everything.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            halt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            halt_q  <= halt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: flush beats stall beats load. The default is hold, which covers stall.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        halt_d  = halt_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_RUN: begin
                if (i_flush) begin
                    instr_d = '0;
                    valid_d = 1'b0;
                end else if (i_enable) begin
                    pc_d    = i_pc_plus4;
                    instr_d = i_instr;
                    valid_d = 1'b1;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + NB_CNT'(1);
                    end
                    // The halt word itself is still presented to ID and counted.
                    if (i_instr == HALT_WORD) begin
                        halt_d  = 1'b1;
                        state_d = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                // The front end is frozen. Any enabled or flush edge drains to a bubble.
                if (i_flush || i_enable) begin
                    instr_d = '0;
                    valid_d = 1'b0;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign o_pc_plus4    = pc_q;
    assign o_instr       = instr_q;
    assign o_valid       = valid_q;
    assign o_halt        = halt_q;
    assign o_instr_count = cnt_q;

endmodule

// File: tb/tb_if_id_latch.sv
module tb_if_id_latch;

    localparam int unsigned NB_CNT = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en  = 1'b0;
    logic              fl  = 1'b0;
    logic [31:0]       pc_in = '0;
    logic [31:0]       instr_in = '0;
    logic [31:0]       pc_out;
    logic [31:0]       instr_out;
    logic              valid_out;
    logic              halt_out;
    logic [NB_CNT-1:0] cnt_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic              rst;
        logic              en;
        logic              fl;
        logic [31:0]       pc;
        logic [31:0]       instr;
        logic [31:0]       e_pc;
        logic [31:0]       e_instr;
        logic              e_valid;
        logic              e_halt;
        logic [NB_CNT-1:0] e_cnt;
    } vec_t;

    typedef struct {
        logic [31:0]       pc;
        logic [31:0]       instr;
        logic              valid;
        logic              halt;
        logic [NB_CNT-1:0] cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    if_id_latch #(
        .NB_ADDR   (32),
        .NB_INSTR  (32),
        .NB_CNT    (NB_CNT),
        .HALT_WORD (32'hFFFF_FFFF)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_enable      (en),
        .i_flush       (fl),
        .i_pc_plus4    (pc_in),
        .i_instr       (instr_in),
        .o_pc_plus4    (pc_out),
        .o_instr       (instr_out),
        .o_valid       (valid_out),
        .o_halt        (halt_out),
        .o_instr_count (cnt_out)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic e, input logic f,
                                input logic [31:0] p, input logic [31:0] i,
                                input logic [31:0] ep, input logic [31:0] ei,
                                input logic ev, input logic eh, input int ec);
        vec_t v;
        v.rst = r; v.en = e; v.fl = f; v.pc = p; v.instr = i;
        v.e_pc = ep; v.e_instr = ei; v.e_valid = ev; v.e_halt = eh;
        v.e_cnt = NB_CNT'(ec);
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    // Drive one vector, queue its expectation, then compare after the edge.
    task automatic step(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        rst = v.rst; en = v.en; fl = v.fl; pc_in = v.pc; instr_in = v.instr;
        e.pc = v.e_pc; e.instr = v.e_instr; e.valid = v.e_valid;
        e.halt = v.e_halt; e.cnt = v.e_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty step %0d", idx);
        end else begin
            e = sb.pop_front();
            chk("pc_plus4",    idx, pc_out,             e.pc);
            chk("instr",       idx, instr_out,          e.instr);
            chk("valid",       idx, 32'(valid_out),     32'(e.valid));
            chk("halt",        idx, 32'(halt_out),      32'(e.halt));
            chk("instr_count", idx, 32'(cnt_out),       32'(e.cnt));
        end
    endtask

    initial begin
        // Reset, then two loads.
        add(1,0,0, 32'h0,  32'h0,        32'h0, 32'h0,        0,0,0);
        add(1,0,0, 32'h0,  32'h0,        32'h0, 32'h0,        0,0,0);
        add(0,1,0, 32'h4,  32'h20080005, 32'h4, 32'h20080005, 1,0,1);
        add(0,1,0, 32'h8,  32'h20090003, 32'h8, 32'h20090003, 1,0,2);
        // Stall for three cycles while the inputs change, then re-enable.
        add(0,1,0, 32'h4,  32'h20080005, 32'h4, 32'h20080005, 1,0,3);
        for (int i = 0; i < 3; i++)
            add(0,0,0, 32'hC, 32'h01095020, 32'h4, 32'h20080005, 1,0,3);
        add(0,1,0, 32'hC,  32'h01095020, 32'hC, 32'h01095020, 1,0,4);
        add(0,1,0, 32'h8,  32'h20090003, 32'h8, 32'h20090003, 1,0,5);
        // Flush during a stall, then a flush that coincides with a HALT word.
        add(0,0,1, 32'h10, 32'h12345678, 32'h8, 32'h0,        0,0,5);
        add(0,1,1, 32'h10, 32'hFFFFFFFF, 32'h8, 32'h0,        0,0,5);
        // Latch a HALT word, stall, then drain it and stay frozen.
        add(0,1,0, 32'h10, 32'hFFFFFFFF, 32'h10, 32'hFFFFFFFF, 1,1,6);
        add(0,0,0, 32'h14, 32'h20080001, 32'h10, 32'hFFFFFFFF, 1,1,6);
        add(0,1,0, 32'h14, 32'h20080001, 32'h10, 32'h0,        0,1,6);
        for (int i = 0; i < 10; i++)
            add(0,1,0, 32'h18 + 32'(4*i), 32'h20080002 + 32'(i), 32'h10, 32'h0, 0,1,6);
        // Reset out of HALTED; loads resume.
        add(1,1,0, 32'h4,  32'h20080005, 32'h0, 32'h0,        0,0,0);
        add(0,1,0, 32'h4,  32'h20080005, 32'h4, 32'h20080005, 1,0,1);
        // The counter saturates at 15 and does not wrap.
        for (int k = 1; k <= 17; k++)
            add(0,1,0, 32'h100 + 32'(4*k), 32'h20000000 + 32'(k),
                32'h100 + 32'(4*k), 32'h20000000 + 32'(k), 1,0, (k+1 > 15) ? 15 : k+1);
        // Reset during HALTED with a stall.
        add(0,1,0, 32'h40, 32'hFFFFFFFF, 32'h40, 32'hFFFFFFFF, 1,1,15);
        add(1,0,0, 32'h44, 32'h20080001, 32'h0,  32'h0,        0,0,0);
        add(0,1,0, 32'h4,  32'h20080005, 32'h4,  32'h20080005, 1,0,1);

        foreach (vecs[i]) step(vecs[i], i);

        // Hand-written sequence: in HALTED, a flush with the stage stalled still drains the halt word.
        begin
            vec_t v;
            v = '{rst:0, en:1, fl:0, pc:32'h50, instr:32'hFFFFFFFF,
                  e_pc:32'h50, e_instr:32'hFFFFFFFF, e_valid:1, e_halt:1, e_cnt:NB_CNT'(2)};
            step(v, 1000);
            v = '{rst:0, en:0, fl:1, pc:32'h54, instr:32'h11111111,
                  e_pc:32'h50, e_instr:32'h0, e_valid:0, e_halt:1, e_cnt:NB_CNT'(2)};
            step(v, 1001);
            v = '{rst:0, en:1, fl:0, pc:32'h58, instr:32'h22222222,
                  e_pc:32'h50, e_instr:32'h0, e_valid:0, e_halt:1, e_cnt:NB_CNT'(2)};
            step(v, 1002);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
